// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
//
// Parametrised UART transmitter fed by a small byte FIFO. Bytes pushed on the
// in_data/in_valid/in_ready handshake are queued and sent as
// start + DATA_BITS (LSB first) + optional parity + STOP_BITS stop bits,
// every bit lasting DIV = round(CLK_FREQ / BAUD) clock cycles.
//
// Handshake: a byte is taken on a rising edge where in_valid && in_ready.
// in_ready is the inverse of a registered full flag, so a push offered while
// the FIFO is full is refused even if a pop happens on the same edge; the
// producer keeps in_data stable until it sees the byte taken.
//
// Ports:
//   clk_50M     in   system clock, all logic on the rising edge
//   reset_btn   in   synchronous active-high reset
//   in_data     in   [DATA_BITS-1:0] byte to enqueue
//   in_valid    in   producer offers in_data
//   in_ready    out  FIFO can accept (registered !full)
//   tx_en       in   permits new frames to start; a frame in flight completes
//   txd         out  registered serial line, idle high
//   busy        out  a frame is in flight
//   frame_done  out  one-cycle pulse on the last cycle of the final stop bit
//   fifo_count  out  bytes queued, excluding the byte being shifted out
// -----------------------------------------------------------------------------
module uart_frame_tx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        clk_50M,
   input  logic                        reset_btn,
   input  logic [DATA_BITS-1:0]        in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        tx_en,
   output logic                        txd,
   output logic                        busy,
   output logic                        frame_done,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   // Bit period rounded to the nearest whole cycle.
   localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int BIT_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(DIV - 1);
   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
   localparam logic [AW:0]      DEPTH_V   = (AW + 1)'(FIFO_DEPTH);

   // ---------------------------------------------------------------------------
   // Byte FIFO
   // ---------------------------------------------------------------------------
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          count;
   logic [AW:0]          count_next;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] fifo_head;

   assign empty      = (count == '0);
   assign push       = in_valid && !full;
   assign in_ready   = !full;
   assign fifo_count = count;
   assign fifo_head  = mem[rd_ptr];

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk_50M) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Pointers are exactly AW bits wide, so they wrap modulo FIFO_DEPTH.
   always_ff @(posedge clk_50M) begin
      if (reset_btn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;
         full  <= (count_next == DEPTH_V);
      end
   end

   // ---------------------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------------------
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t               state;
   state_t               state_n;
   logic [CNT_W-1:0]     baud_cnt;
   logic [CNT_W-1:0]     baud_n;
   logic [BIT_W-1:0]     bit_cnt;
   logic [BIT_W-1:0]     bit_n;
   logic [DATA_BITS-1:0] sh;
   logic [DATA_BITS-1:0] sh_n;
   logic                 par_q;
   logic                 par_n;
   logic                 txd_q;
   logic                 txd_n;
   logic                 bit_end;
   logic                 start_ok;
   logic                 load;

   // The baud counter is loaded with DIV-1 as a bit begins, so reaching zero
   // marks the last of that bit's DIV cycles.
   assign bit_end  = (baud_cnt == '0);
   assign start_ok = tx_en && !empty;
   assign txd      = txd_q;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk_50M) begin
      if (reset_btn) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         sh       <= '0;
         par_q    <= 1'b0;
         txd_q    <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
         sh       <= sh_n;
         par_q    <= par_n;
         txd_q    <= txd_n;
      end
   end

   always_comb begin
      state_n    = state;
      baud_n     = baud_cnt;
      bit_n      = bit_cnt;
      sh_n       = sh;
      par_n      = par_q;
      txd_n      = txd_q;
      load       = 1'b0;
      pop        = 1'b0;
      frame_done = 1'b0;

      if (state != IDLE && !bit_end) begin
         baud_n = baud_cnt - 1'b1;
      end

      case (state)
         IDLE: begin
            txd_n = 1'b1;
            if (start_ok) begin
               load = 1'b1;
            end
         end

         START: begin
            if (bit_end) begin
               state_n = DATA;
               baud_n  = DIV_M1;
               bit_n   = '0;
               txd_n   = sh[0];
            end
         end

         DATA: begin
            if (bit_end) begin
               baud_n = DIV_M1;
               if (bit_cnt == LAST_DATA) begin
                  bit_n = '0;
                  if (PARITY != 0) begin
                     state_n = PAR;
                     txd_n   = par_q;
                  end else begin
                     state_n = STOP;
                     txd_n   = 1'b1;
                  end
               end else begin
                  // sh[1] is the next payload bit once the register shifts.
                  bit_n = bit_cnt + 1'b1;
                  sh_n  = {1'b0, sh[DATA_BITS-1:1]};
                  txd_n = sh[1];
               end
            end
         end

         PAR: begin
            if (bit_end) begin
               state_n = STOP;
               baud_n  = DIV_M1;
               bit_n   = '0;
               txd_n   = 1'b1;
            end
         end

         STOP: begin
            if (bit_end) begin
               if (bit_cnt == LAST_STOP) begin
                  frame_done = 1'b1;
                  // Chain straight into the next start bit when possible so
                  // back-to-back frames have no idle gap.
                  if (start_ok) begin
                     load = 1'b1;
                  end else begin
                     state_n = IDLE;
                     txd_n   = 1'b1;
                  end
               end else begin
                  bit_n  = bit_cnt + 1'b1;
                  baud_n = DIV_M1;
               end
            end
         end

         default: begin
            state_n = IDLE;
            txd_n   = 1'b1;
         end
      endcase

      // Pop the FIFO head and begin the start bit on the next edge. Parity is
      // computed once here from the whole byte.
      if (load) begin
         pop     = 1'b1;
         sh_n    = fifo_head;
         par_n   = (^fifo_head) ^ (PARITY == 1);
         baud_n  = DIV_M1;
         bit_n   = '0;
         state_n = START;
         txd_n   = 1'b0;
      end
   end

endmodule
